uart_tx_arbiter: RTL

- Shares the single uart_top transmit channel among NUM_REQ byte requesters, for example rx loopback echo, error-report message generator and status beacon.
- Round-robin arbitration, with optional packet lock so multi-byte messages are never interleaved.
- Sequences exactly one tx_byte_valid pulse per byte, then waits for the transmitter to start and finish before the next grant.
- Sits between the requesters and uart_top tx_byte_valid/tx_byte_data/tx_active/tx_done, in the arty_a7_100_top clock domain.

---
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of the single uart_top transmit channel
// among NUM_REQ byte requesters, with packet lock so multi-byte messages stay
// contiguous. One byte in flight: accept, issue strobe, wait start, wait done.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int PACK_SIZE     = 8,
  parameter int START_TIMEOUT = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         CLK100MHZ,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*PACK_SIZE-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]           req_last_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic                         tx_byte_valid_o,
  output logic [PACK_SIZE-1:0]         tx_byte_data_o,
  input  logic                         tx_active_i,
  input  logic                         tx_done_i,
  output logic [IW-1:0]                grant_id_o,
  output logic                         busy_o,
  output logic                         locked_o,
  output logic                         start_err_o,
  output logic                         lock_err_o
);
  localparam int SCW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam int LCW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [SCW-1:0] SMAX = SCW'(START_TIMEOUT - 1);
  localparam logic [LCW-1:0] LMAX = LCW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, grant_id_q, win_idx;
  logic                 lock_q, act_prev_q, win_found;
  logic [PACK_SIZE-1:0] tx_data_q;
  logic [SCW-1:0]       start_cnt_q;
  logic [LCW-1:0]       lock_cnt_q;
  logic                 accept, start_to, lock_to, lock_idle;
  int                   cand;

  // Index after x, wrapping at NUM_REQ (always 0 when NUM_REQ==1).
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
    if (int'(x) >= NUM_REQ - 1) return '0;
    return x + 1'b1;
  endfunction

  // Winner select: locked owner only, else first valid from rr_ptr upward.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    if (lock_q) begin
      win_found = req_valid_i[grant_id_q];
      win_idx   = grant_id_q;
    end else begin
      // Scan downward so the lowest offset from rr_ptr is assigned last and wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = (int'(rr_ptr_q) + k) % NUM_REQ;
        if (req_valid_i[cand]) begin
          win_found = 1'b1;
          win_idx   = IW'(cand);
        end
      end
    end
  end

  assign accept    = (state_q == IDLE) && win_found && !reset;
  assign lock_idle = (state_q == IDLE) && lock_q && !req_valid_i[grant_id_q];
  assign lock_to   = lock_idle && (lock_cnt_q == LMAX) && !reset;
  assign start_to  = (state_q == WAIT_START) && !tx_active_i && (start_cnt_q == SMAX) && !reset;

  assign req_ready_o     = accept ? (NUM_REQ'(1) << win_idx) : '0;
  assign tx_byte_valid_o = (state_q == ISSUE) && !reset;
  assign tx_byte_data_o  = tx_data_q;
  assign grant_id_o      = grant_id_q;
  assign busy_o          = (state_q != IDLE);
  assign locked_o        = lock_q;
  assign start_err_o     = start_to;
  assign lock_err_o      = lock_to;

  // Sequencer next state: one issue per accepted byte, then start/done handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (accept) state_d = ISSUE;
      ISSUE:      state_d = WAIT_START;
      WAIT_START: begin
        // A done pulse coincident with the start skips WAIT_DONE entirely.
        if (tx_active_i)  state_d = tx_done_i ? IDLE : WAIT_DONE;
        else if (start_to) state_d = IDLE;
      end
      WAIT_DONE:  if (tx_done_i || (act_prev_q && !tx_active_i)) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Byte capture, lock/round-robin bookkeeping and saturating timeout counters.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      lock_q      <= 1'b0;
      tx_data_q   <= '0;
      start_cnt_q <= '0;
      lock_cnt_q  <= '0;
      act_prev_q  <= 1'b0;
    end else begin
      act_prev_q <= tx_active_i;
      if (accept) begin
        tx_data_q  <= req_data_i[int'(win_idx)*PACK_SIZE +: PACK_SIZE];
        grant_id_q <= win_idx;
        lock_cnt_q <= '0;
        if (req_last_i[win_idx]) begin
          lock_q   <= 1'b0;
          rr_ptr_q <= nxt(win_idx);
        end else begin
          lock_q   <= 1'b1;
        end
      end else if (lock_to) begin
        // Stalled owner: drop the lock and move fairness past it.
        lock_q     <= 1'b0;
        rr_ptr_q   <= nxt(grant_id_q);
        lock_cnt_q <= '0;
      end else if (lock_idle && lock_cnt_q != LMAX) begin
        lock_cnt_q <= lock_cnt_q + 1'b1;
      end
      if (state_q == ISSUE)
        start_cnt_q <= '0;
      else if (state_q == WAIT_START && !tx_active_i && start_cnt_q != SMAX)
        start_cnt_q <= start_cnt_q + 1'b1;
    end
  end
endmodule
